// File: rtl/adder_tree_pkg.sv
// Shared defaults and sizing helpers for the adder tree and its arbiter.
// Provides operand count/width defaults, tree latency and ID width.
package adder_tree_pkg;

  localparam int NUM_DEF = 18;
  localparam int LEN_DEF = 16;

  // One register level per halving of the operand count.
  function automatic int tree_lat_f(input int n);
    return $clog2(n);
  endfunction

  function automatic int id_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_tree_arbiter_rr.sv
// Round-robin one-hot grant: scans req from ptr upward, wrapping mod N.
// in: en, req[N], ptr; out: grant[N] (one-hot), gidx, any.
module rr_arbiter
  import adder_tree_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w_f(N)
) (
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx,
  output logic          any
);

  int idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N)
        idx = idx - N;
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one pipelined adder tree among NREQ requesters, tagging sums with IDs.
// in: en, req_valid/req_data, tree_sum; out: req_ready, tree_in, res_*, busy.
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter  int NUM      = NUM_DEF,
  parameter  int LEN      = LEN_DEF,
  parameter  int NREQ     = 4,
  parameter  int TREE_LAT = tree_lat_f(NUM_DEF),
  localparam int ID_W     = id_w_f(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*NUM*LEN-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NUM*LEN-1:0]      tree_in,
  input  logic [LEN-1:0]          tree_sum,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [LEN-1:0]          res_sum,
  output logic                    busy
);

  localparam int VW = NUM * LEN;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] gidx;
  logic            acc;

  rr_arbiter #(.N(NREQ)) u_arb (
    .en    (en),
    .req   (req_valid),
    .ptr   (ptr),
    .grant (req_ready),
    .gidx  (gidx),
    .any   (acc)
  );

  always_comb begin
    ptr_nxt = '0;
    if (int'(gidx) != NREQ - 1)
      ptr_nxt = gidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      tree_in <= '0;
    end else if (acc) begin
      ptr     <= ptr_nxt;
      tree_in <= req_data[int'(gidx)*VW +: VW];
    end
  end

  // Entry 0 lines up with tree_in; entry TREE_LAT lines up
  // with the matching tree_sum, so it is the last stage.
  logic [TREE_LAT:0] tv;
  logic [ID_W-1:0]   tid [TREE_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= '0;
      for (int i = 0; i <= TREE_LAT; i++)
        tid[i] <= '0;
    end else begin
      tv[0] <= acc;
      if (acc)
        tid[0] <= gidx;
      for (int i = 1; i <= TREE_LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
    end else begin
      res_valid <= tv[TREE_LAT];
      if (tv[TREE_LAT]) begin
        res_id  <= tid[TREE_LAT];
        res_sum <= tree_sum;
      end
    end
  end

  assign busy = (|tv) | res_valid;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Self-checking bench for adder_tree_arbiter with a behavioural adder tree.
// Scoreboard predicts grants, result timing, ids, sums and busy.
module tb_adder_tree_arbiter;
  import adder_tree_pkg::*;

  localparam int NUM  = 18;
  localparam int LEN  = 16;
  localparam int NREQ = 4;
  localparam int TL   = 5;
  localparam int VW   = NUM * LEN;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*VW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [VW-1:0]        tree_in;
  logic [LEN-1:0]       tree_sum;
  logic                 res_valid;
  logic [1:0]           res_id;
  logic [LEN-1:0]       res_sum;
  logic                 busy;

  adder_tree_arbiter #(
    .NUM(NUM), .LEN(LEN), .NREQ(NREQ), .TREE_LAT(TL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tree_in   (tree_in),
    .tree_sum  (tree_sum),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LEN-1:0] op_sum(input logic [VW-1:0] v);
    int s;
    s = 0;
    for (int j = 0; j < NUM; j++)
      s += int'(v[j*LEN +: LEN]);
    return LEN'(s);
  endfunction

  // behavioural adder tree: TL edges from tree_in to tree_sum
  logic [LEN-1:0] tp [TL];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TL; i++) tp[i] <= '0;
    end else begin
      tp[0] <= op_sum(tree_in);
      for (int i = 1; i < TL; i++) tp[i] <= tp[i-1];
    end
  end
  assign tree_sum = tp[TL-1];

  typedef struct {
    int             due;
    int             id;
    logic [LEN-1:0] sum;
  } pend_t;

  typedef struct {
    int             id;
    logic [LEN-1:0] sum;
  } res_t;

  typedef struct {
    bit              en;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] rdy;
  } vec_t;

  pend_t          pend [$];
  res_t           rlog [$];
  int             mptr;
  int             cyc;
  logic [VW-1:0]  m_in;
  int             m_id;
  logic [LEN-1:0] m_sum;
  int             total;
  int             bad;
  int             last_g;

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int r, input logic [LEN-1:0] val);
    for (int j = 0; j < NUM; j++)
      req_data[(r*NUM+j)*LEN +: LEN] = val;
  endtask

  task automatic set_rand(input int r);
    for (int j = 0; j < NUM; j++)
      req_data[(r*NUM+j)*LEN +: LEN] = LEN'($urandom);
  endtask

  task automatic model_reset();
    pend.delete();
    mptr  = 0;
    m_in  = '0;
    m_id  = 0;
    m_sum = '0;
  endtask

  // One clock: predict grant, check ready, advance, check outputs.
  task automatic cycle(input logic [NREQ-1:0] exp_rdy, input bit use_tab);
    int              g;
    int              idx;
    logic [NREQ-1:0] er;
    bit              ev;
    pend_t           p;
    #1;
    g = -1;
    if (en)
      for (int i = 0; i < NREQ; i++) begin
        idx = (mptr + i) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", req_ready, er);
    if (use_tab) chk("tab_ready", req_ready, exp_rdy);
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      p.due = cyc + TL + 1;
      p.id  = g;
      p.sum = op_sum(req_data[g*VW +: VW]);
      pend.push_back(p);
      m_in = req_data[g*VW +: VW];
      mptr = (g + 1) % NREQ;
    end
    last_g = g;
    @(negedge clk);
    chk("busy", busy, pend.size() != 0);
    ev = pend.size() != 0 && pend[0].due == cyc;
    chk("res_valid", res_valid, ev);
    if (ev) begin
      m_id  = pend[0].id;
      m_sum = pend[0].sum;
      rlog.push_back('{m_id, m_sum});
      void'(pend.pop_front());
    end
    chk("res_id", res_id, m_id);
    chk("res_sum", res_sum, m_sum);
    chk("tree_in", tree_in, m_in);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tree_in", tree_in, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < 20 && pend.size() != 0; i++)
      cycle('0, 1'b0);
    cycle('0, 1'b0);
    chk("drain_busy", busy, 0);
  endtask

  vec_t tab [11];
  int   n;

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    last_g = -1;
    rst_n = 1'b1;
    en = 1'b0;
    req_valid = '0;
    req_data = '0;
    model_reset();
    #2;
    do_reset();
    en = 1'b1;
    cycle('0, 1'b1);

    // 1: single requester, all ones
    set_ops(1, 16'd1);
    req_valid = 4'b0010;
    cycle(4'b0010, 1'b1);
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle('0, 1'b0);
      n++;
      if (res_valid) break;
    end
    chk("t1_latency", n, 6);
    chk("t1_id", res_id, 1);
    chk("t1_sum", res_sum, 18);
    drain();

    // grant table, starting with ptr=2
    tab[0]  = '{1'b1, 4'b0001, 4'b0001};
    tab[1]  = '{1'b1, 4'b0101, 4'b0100};
    tab[2]  = '{1'b1, 4'b0001, 4'b0001};
    tab[3]  = '{1'b0, 4'b1111, 4'b0000};
    tab[4]  = '{1'b1, 4'b0000, 4'b0000};
    tab[5]  = '{1'b1, 4'b1001, 4'b1000};
    tab[6]  = '{1'b1, 4'b1111, 4'b0001};
    tab[7]  = '{1'b1, 4'b1110, 4'b0010};
    tab[8]  = '{1'b1, 4'b0011, 4'b0001};
    tab[9]  = '{1'b1, 4'b1100, 4'b0100};
    tab[10] = '{1'b1, 4'b0110, 4'b0010};
    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < NREQ; r++) set_rand(r);
      en = tab[i].en;
      req_valid = tab[i].v;
      cycle(tab[i].rdy, 1'b1);
    end
    en = 1'b1;
    drain();

    // 3: negative operands and wrap (ptr=2 here)
    rlog.delete();
    set_ops(0, 16'hFFFF);
    req_valid = 4'b0001;
    cycle(4'b0001, 1'b1);
    set_ops(0, 16'h7FFF);
    cycle(4'b0001, 1'b1);
    drain();
    chk("t3_count", rlog.size(), 2);
    if (rlog.size() >= 2) begin
      chk("t3_neg", rlog[0].sum, 16'hFFEE);
      chk("t3_wrap", rlog[1].sum, 16'hFFEE);
      chk("t3_id", rlog[1].id, 0);
    end

    // 2: all valid from reset, back-to-back
    do_reset();
    rlog.delete();
    for (int r = 0; r < NREQ; r++) set_ops(r, LEN'(r + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      logic [NREQ-1:0] e;
      e = '0;
      e[i % 4] = 1'b1;
      cycle(e, 1'b1);
    end
    drain();
    chk("t2_count", rlog.size(), 8);
    if (rlog.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk("t2_id", rlog[i].id, i % 4);
        chk("t2_sum", rlog[i].sum, 18 * (i % 4 + 1));
      end

    // 5: en drops with 3 in flight
    rlog.delete();
    for (int r = 0; r < NREQ; r++) set_rand(r);
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b0);
      set_rand(last_g);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) cycle('0, 1'b1);
    chk("t5_count", rlog.size(), 3);
    chk("t5_busy", busy, 0);
    en = 1'b1;

    // 6: reset with 3 in flight
    rlog.delete();
    for (int i = 0; i < 3; i++) cycle('0, 1'b0);
    do_reset();
    rlog.delete();
    cycle(4'b0001, 1'b1);
    req_valid = '0;
    for (int i = 0; i < 10; i++) cycle('0, 1'b0);
    chk("t6_count", rlog.size(), 1);

    // random traffic, requesters hold until accepted
    req_valid = '0;
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < NREQ; r++)
        if (!req_valid[r] || last_g == r) begin
          req_valid[r] = $urandom_range(0, 2) != 0;
          set_rand(r);
        end
      en = $urandom_range(0, 9) != 0;
      cycle('0, 1'b0);
    end
    en = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
